// File: rtl/pwm_bank_if.sv
// pwm_bank_if: duty write port plus PWM status outputs for pwm_bank.
// The master side (sequencer or bench) drives the write strobe, channel
// index and duty value, and observes the PWM pins and status flags.
// The slave side is the PWM bank itself.
interface pwm_bank_if #(
    parameter int CHANNELS     = 2,
    parameter int COUNTER_BITS = 4
) ();
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                    wr_en;
    logic [CH_W-1:0]         wr_ch;
    logic [COUNTER_BITS-1:0] wr_duty;
    logic [CHANNELS-1:0]     pwm;
    logic                    period_end;
    logic                    settled;

    modport master (
        output wr_en,
        output wr_ch,
        output wr_duty,
        input  pwm,
        input  period_end,
        input  settled
    );

    modport slave (
        input  wr_en,
        input  wr_ch,
        input  wr_duty,
        output pwm,
        output period_end,
        output settled
    );
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator with a shared free-running counter.
// Each channel compares its active duty against the counter plus a fixed
// per-channel phase offset, so switching edges are spread over the period.
// Duty writes land in shadow registers and are copied into the active set
// only when the counter wraps, keeping every output glitch-free.
//
// Optional feature macro: PWM_BANK_RAMP_EN
//   defined   -> at each wrap, active duty steps by one toward its shadow
//   undefined -> at each wrap, active duty jumps straight to its shadow
module pwm_bank #(
    parameter int CHANNELS     = 2,
    parameter int COUNTER_BITS = 4,
    parameter int PRESCALE     = 1
) (
    input  logic      clk,
    input  logic      rst,
    pwm_bank_if.slave bus
);
    localparam int N      = COUNTER_BITS;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int OFFSET = (1 << N) / CHANNELS;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [N-1:0]     CNT_MAX = {N{1'b1}};

    // Reject parameter sets that cannot work; more channels than counter
    // steps would collapse the phase offset to zero.
    generate
        if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
            $error("pwm_bank: CHANNELS must be in 1..16");
        end
        if (COUNTER_BITS < 2 || COUNTER_BITS > 16) begin : g_bad_bits
            $error("pwm_bank: COUNTER_BITS must be in 2..16");
        end
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $error("pwm_bank: PRESCALE must be in 1..65535");
        end
        if (CHANNELS > (1 << COUNTER_BITS)) begin : g_bad_offset
            $error("pwm_bank: CHANNELS exceeds 2**COUNTER_BITS, phase offset would be 0");
        end
    endgenerate

    // State
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [N-1:0]        cnt_q, cnt_d;
    logic [N-1:0]        shadow_q [CHANNELS];
    logic [N-1:0]        shadow_d [CHANNELS];
    logic [N-1:0]        active_q [CHANNELS];
    logic [N-1:0]        active_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                period_end_q, period_end_d;

    // Derived timing strobes
    logic                tick;
    logic                wrap;
    logic [N-1:0]        ph [CHANNELS];
    logic [CHANNELS-1:0] chan_eq;

    assign tick = (pre_q == PRE_MAX);
    assign wrap = tick && (cnt_q == CNT_MAX);

    // Per-channel phased counter view; the addition is modulo 2**N.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_phase
            localparam logic [N-1:0] PH_OFF = N'(gi * OFFSET);
            assign ph[gi] = cnt_q + PH_OFF;
        end
    endgenerate

    // Prescaler and shared counter advance.
    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (tick) begin
            pre_d = '0;
            cnt_d = cnt_q + N'(1);
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Shadow writes; an index outside the channel range matches nothing.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
                shadow_d[i] = bus.wr_duty;
            end
        end
    end

    // Active duty update at the period boundary, always from the shadow value
    // held before any write in the same cycle.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            active_d[i] = active_q[i];
            if (wrap) begin
`ifdef PWM_BANK_RAMP_EN
                if (active_q[i] < shadow_q[i]) begin
                    active_d[i] = active_q[i] + N'(1);
                end else if (active_q[i] > shadow_q[i]) begin
                    active_d[i] = active_q[i] - N'(1);
                end
`else
                active_d[i] = shadow_q[i];
`endif
            end
        end
    end

    // Duty compare against the phased counter and settle detection.
    always_comb begin
        pwm_d   = '0;
        chan_eq = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i]   = (active_q[i] > ph[i]);
            chan_eq[i] = (active_q[i] == shadow_q[i]);
        end
    end

    // Period boundary flag appears together with the new active values.
    always_comb begin
        period_end_d = wrap;
    end

    // All state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q        <= '0;
            cnt_q        <= '0;
            pwm_q        <= '0;
            period_end_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign bus.pwm        = pwm_q;
    assign bus.period_end = period_end_q;
    assign bus.settled    = &chan_eq;

endmodule
